// File: rtl/ring_pkg.sv
// Shared types and constants for the one-hot ring phase decoder.
package ring_pkg;

    localparam int RING_W = 4;
    localparam int IDX_W  = 2;
    localparam logic [RING_W-1:0] CLR_PATTERN = 4'b1000;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/ring_onehot_enc.sv
// Combinational one-hot check and binary encode of a ring counter phase vector.
module ring_onehot_enc
    import ring_pkg::*;
(
    input  logic [RING_W-1:0] q,
    output logic              valid,
    output logic [IDX_W-1:0]  idx
);

    // The clear pattern is phase 0; phases count up as the hot bit moves right.
    always_comb begin
        valid = 1'b1;
        idx   = '0;
        case (q)
            CLR_PATTERN: idx = 2'd0;
            4'b0100:     idx = 2'd1;
            4'b0010:     idx = 2'd2;
            4'b0001:     idx = 2'd3;
            default:     valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/ring_decode.sv
// Tracks a sampled 4-bit ring counter, declares lock after LOCK_CNT in-sequence
// steps and counts sequence errors seen while locked.
module ring_decode
    import ring_pkg::*;
#(
    parameter int LOCK_CNT = 2
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              en,
    input  logic [RING_W-1:0] q,
    output logic [IDX_W-1:0]  idx,
    output logic              idx_vld,
    output logic              locked,
    output logic              err,
    output logic [7:0]        err_cnt
);

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         good_cnt;
    logic [3:0]         good_nxt;
    logic [3:0]         good_inc;
    logic [IDX_W-1:0]   idx_nxt;
    logic [IDX_W-1:0]   exp_idx;
    logic               vld_nxt;
    logic               err_nxt;
    logic               s_valid;
    logic [IDX_W-1:0]   s_idx;
    logic               clear_hold;

    ring_onehot_enc u_enc (
        .q     (q),
        .valid (s_valid),
        .idx   (s_idx)
    );

    // idx doubles as the previous valid index, so it also predicts the next phase.
    assign exp_idx    = idx + IDX_W'(1);
    assign good_inc   = good_cnt + 4'd1;
    assign clear_hold = s_valid && (q == CLR_PATTERN) && (idx == '0);

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        idx_nxt   = idx;
        vld_nxt   = 1'b0;
        err_nxt   = 1'b0;
        if (en) begin
            vld_nxt = s_valid;
            if (s_valid) begin
                idx_nxt = s_idx;
            end
            // A ring parked in clear is not a fault; restart qualification instead.
            if (clear_hold) begin
                state_nxt = CHECK;
                good_nxt  = '0;
            end else begin
                case (state)
                    HUNT: begin
                        if (s_valid) begin
                            state_nxt = CHECK;
                            good_nxt  = '0;
                        end
                    end
                    CHECK: begin
                        if (!s_valid) begin
                            state_nxt = HUNT;
                        end else if (s_idx == exp_idx) begin
                            good_nxt = good_inc;
                            if (good_inc == 4'(LOCK_CNT)) begin
                                state_nxt = LOCKED;
                            end
                        end else begin
                            good_nxt = '0;
                        end
                    end
                    LOCKED: begin
                        if (!(s_valid && (s_idx == exp_idx))) begin
                            err_nxt   = 1'b1;
                            state_nxt = HUNT;
                            good_nxt  = '0;
                        end
                    end
                    default: begin
                        state_nxt = HUNT;
                        good_nxt  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= HUNT;
            good_cnt <= '0;
            idx      <= '0;
            idx_vld  <= 1'b0;
            locked   <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            idx      <= idx_nxt;
            idx_vld  <= vld_nxt;
            locked   <= (state_nxt == LOCKED);
            err      <= err_nxt;
            if (err_nxt && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ring_decode.sv
// Scenario and randomized checks of ring_decode against a sample-by-sample reference model.
module tb_ring_decode;

    localparam int LOCK_CNT = 2;
    localparam int M_HUNT   = 0;
    localparam int M_CHECK  = 1;
    localparam int M_LOCKED = 2;

    logic       clk;
    logic       clr_n;
    logic       en;
    logic [3:0] q;
    logic [1:0] idx;
    logic       idx_vld;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    int m_idx;
    int m_mode;
    int m_run;
    int m_err_cnt;
    bit m_vld;
    bit m_err;

    ring_decode #(.LOCK_CNT(LOCK_CNT)) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .en      (en),
        .q       (q),
        .idx     (idx),
        .idx_vld (idx_vld),
        .locked  (locked),
        .err     (err),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] base;
        base = 4'b1000;
        return base >> (i % 4);
    endfunction

    task automatic model_reset();
        m_idx     = 0;
        m_mode    = M_HUNT;
        m_run     = 0;
        m_err_cnt = 0;
        m_vld     = 0;
        m_err     = 0;
    endtask

    // Reference behaviour of one sampling edge, written from the phase rules.
    task automatic model_update(input logic [3:0] qv, input logic env);
        bit valid;
        int v;
        int nxt;
        valid = ($countones(qv) == 1);
        v = 0;
        for (int b = 0; b < 4; b++) if (qv[b]) v = 3 - b;
        nxt   = (m_idx + 1) % 4;
        m_vld = 0;
        m_err = 0;
        if (env) begin
            m_vld = valid;
            if (valid && qv == 4'b1000 && m_idx == 0) begin
                m_mode = M_CHECK;
                m_run  = 0;
            end else if (m_mode == M_LOCKED) begin
                if (!(valid && v == nxt)) begin
                    m_err = 1;
                    if (m_err_cnt < 255) m_err_cnt++;
                    m_mode = M_HUNT;
                end
            end else if (m_mode == M_CHECK) begin
                if (!valid) m_mode = M_HUNT;
                else if (v == nxt) begin
                    m_run++;
                    if (m_run == LOCK_CNT) m_mode = M_LOCKED;
                end else m_run = 0;
            end else if (valid) begin
                m_mode = M_CHECK;
                m_run  = 0;
            end
            if (valid) m_idx = v;
        end
    endtask

    task automatic step(input logic [3:0] qv, input logic env);
        @(negedge clk);
        q  = qv;
        en = env;
        @(posedge clk);
        model_update(qv, env);
        #1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        en    = 1'b0;
        q     = 4'b0000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks += 5;
        if (idx !== 2'd0) begin errors++; $display("[TB] FAIL reset_idx got %0d want 0", idx); end
        if (idx_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_idx_vld got %0b want 0", idx_vld); end
        if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked got %0b want 0", locked); end
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %0b want 0", err); end
        if (err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_err_cnt got %0d want 0", err_cnt); end
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic test_clean_ring();
        logic [3:0] seq_q [5];
        int         exp_i [5];
        seq_q = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
        exp_i = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            step(seq_q[i], 1'b1);
            checks += 4;
            if (idx !== 2'(exp_i[i])) begin errors++; $display("[TB] FAIL clean_idx[%0d] got %0d want %0d", i, idx, exp_i[i]); end
            if (idx_vld !== 1'b1) begin errors++; $display("[TB] FAIL clean_vld[%0d] got %0b want 1", i, idx_vld); end
            if (err !== 1'b0) begin errors++; $display("[TB] FAIL clean_err[%0d] got %0b want 0", i, err); end
            if (locked !== (i >= 2)) begin errors++; $display("[TB] FAIL clean_locked[%0d] got %0b want %0b", i, locked, (i >= 2)); end
        end
    endtask

    task automatic test_glitch();
        step(4'b0110, 1'b1);
        checks += 5;
        if (err !== 1'b1) begin errors++; $display("[TB] FAIL glitch_err got %0b want 1", err); end
        if (err_cnt !== 8'd1) begin errors++; $display("[TB] FAIL glitch_err_cnt got %0d want 1", err_cnt); end
        if (idx_vld !== 1'b0) begin errors++; $display("[TB] FAIL glitch_vld got %0b want 0", idx_vld); end
        if (idx !== 2'd0) begin errors++; $display("[TB] FAIL glitch_idx_hold got %0d want 0", idx); end
        if (locked !== 1'b0) begin errors++; $display("[TB] FAIL glitch_locked got %0b want 0", locked); end
        for (int i = 1; i <= 3; i++) begin
            step(onehot(i), 1'b1);
            checks += 2;
            if (err !== 1'b0) begin errors++; $display("[TB] FAIL relock_err[%0d] got %0b want 0", i, err); end
            if (locked !== (i == 3)) begin errors++; $display("[TB] FAIL relock_locked[%0d] got %0b want %0b", i, locked, (i == 3)); end
        end
    endtask

    task automatic test_skip();
        step(4'b1000, 1'b1);
        step(4'b0100, 1'b1);
        step(4'b0001, 1'b1);
        checks += 5;
        if (err !== 1'b1) begin errors++; $display("[TB] FAIL skip_err got %0b want 1", err); end
        if (err_cnt !== 8'd2) begin errors++; $display("[TB] FAIL skip_err_cnt got %0d want 2", err_cnt); end
        if (idx !== 2'd3) begin errors++; $display("[TB] FAIL skip_idx got %0d want 3", idx); end
        if (idx_vld !== 1'b1) begin errors++; $display("[TB] FAIL skip_vld got %0b want 1", idx_vld); end
        if (locked !== 1'b0) begin errors++; $display("[TB] FAIL skip_locked got %0b want 0", locked); end
        step(4'b1000, 1'b1);
        step(4'b0100, 1'b1);
        step(4'b0010, 1'b1);
        checks += 2;
        if (locked !== 1'b1) begin errors++; $display("[TB] FAIL skip_relock got %0b want 1", locked); end
        if (err_cnt !== 8'd2) begin errors++; $display("[TB] FAIL skip_cnt_hold got %0d want 2", err_cnt); end
    endtask

    task automatic test_clear_hold();
        step(4'b0001, 1'b1);
        step(4'b1000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(4'b1000, 1'b1);
            checks += 2;
            if (err !== 1'b0) begin errors++; $display("[TB] FAIL hold_err[%0d] got %0b want 0", i, err); end
            if (locked !== 1'b0) begin errors++; $display("[TB] FAIL hold_locked[%0d] got %0b want 0", i, locked); end
        end
        step(4'b0100, 1'b1);
        step(4'b0010, 1'b1);
        checks += 2;
        if (locked !== 1'b1) begin errors++; $display("[TB] FAIL hold_relock got %0b want 1", locked); end
        if (err_cnt !== 8'd2) begin errors++; $display("[TB] FAIL hold_err_cnt got %0d want 2", err_cnt); end
    endtask

    task automatic test_enable_freeze();
        for (int i = 0; i < 5; i++) begin
            step(4'($urandom), 1'b0);
            checks += 5;
            if (err !== 1'b0) begin errors++; $display("[TB] FAIL freeze_err[%0d] got %0b want 0", i, err); end
            if (idx_vld !== 1'b0) begin errors++; $display("[TB] FAIL freeze_vld[%0d] got %0b want 0", i, idx_vld); end
            if (locked !== 1'b1) begin errors++; $display("[TB] FAIL freeze_locked[%0d] got %0b want 1", i, locked); end
            if (idx !== 2'd2) begin errors++; $display("[TB] FAIL freeze_idx[%0d] got %0d want 2", i, idx); end
            if (err_cnt !== 8'd2) begin errors++; $display("[TB] FAIL freeze_err_cnt[%0d] got %0d want 2", i, err_cnt); end
        end
        step(4'b0001, 1'b1);
        checks += 2;
        if (locked !== 1'b1) begin errors++; $display("[TB] FAIL thaw_locked got %0b want 1", locked); end
        if (idx !== 2'd3) begin errors++; $display("[TB] FAIL thaw_idx got %0d want 3", idx); end
    endtask

    task automatic test_async_reset();
        #2;
        clr_n = 1'b0;
        #1;
        checks += 5;
        if (idx !== 2'd0) begin errors++; $display("[TB] FAIL areset_idx got %0d want 0", idx); end
        if (idx_vld !== 1'b0) begin errors++; $display("[TB] FAIL areset_vld got %0b want 0", idx_vld); end
        if (locked !== 1'b0) begin errors++; $display("[TB] FAIL areset_locked got %0b want 0", locked); end
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL areset_err got %0b want 0", err); end
        if (err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL areset_err_cnt got %0d want 0", err_cnt); end
        @(negedge clk);
        clr_n = 1'b1;
        model_reset();
        step(4'b0100, 1'b1);
        checks += 3;
        if (idx !== 2'd1) begin errors++; $display("[TB] FAIL post_reset_idx got %0d want 1", idx); end
        if (locked !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_locked got %0b want 0", locked); end
        if (err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL post_reset_err_cnt got %0d want 0", err_cnt); end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 3; k++) step(onehot(m_idx + 1), 1'b1);
            step(4'b0110, 1'b1);
            checks += 2;
            if (err !== 1'b1) begin errors++; $display("[TB] FAIL sat_err[%0d] got %0b want 1", n, err); end
            if (err_cnt !== 8'(m_err_cnt)) begin errors++; $display("[TB] FAIL sat_err_cnt[%0d] got %0d want %0d", n, err_cnt, m_err_cnt); end
        end
        checks++;
        if (err_cnt !== 8'd255) begin errors++; $display("[TB] FAIL sat_final got %0d want 255", err_cnt); end
    endtask

    task automatic test_random();
        logic [3:0] qv;
        logic       ev;
        int         r;
        for (int i = 0; i < 500; i++) begin
            r  = int'($urandom_range(9));
            ev = ($urandom_range(9) != 0);
            if (r < 6)       qv = onehot(m_idx + 1);
            else if (r == 6) qv = onehot(int'($urandom_range(3)));
            else if (r == 7) qv = 4'($urandom);
            else if (r == 8) qv = 4'b1000;
            else             qv = onehot(m_idx);
            step(qv, ev);
            checks += 5;
            if (idx !== 2'(m_idx)) begin errors++; $display("[TB] FAIL rand_idx[%0d] got %0d want %0d", i, idx, m_idx); end
            if (idx_vld !== m_vld) begin errors++; $display("[TB] FAIL rand_vld[%0d] got %0b want %0b", i, idx_vld, m_vld); end
            if (locked !== (m_mode == M_LOCKED)) begin errors++; $display("[TB] FAIL rand_locked[%0d] got %0b want %0b", i, locked, (m_mode == M_LOCKED)); end
            if (err !== m_err) begin errors++; $display("[TB] FAIL rand_err[%0d] got %0b want %0b", i, err, m_err); end
            if (err_cnt !== 8'(m_err_cnt)) begin errors++; $display("[TB] FAIL rand_err_cnt[%0d] got %0d want %0d", i, err_cnt, m_err_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_ring();
        test_glitch();
        test_skip();
        test_clear_hold();
        test_enable_freeze();
        test_async_reset();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
